lsr_stream: RTL and testbench

Streaming, parametrised least-squares linear-regression engine, successor to the fixed 4/7-point LSR block. It accepts `N` signed samples `y[i]` over a valid/ready stream, with implicit abscissa `x = 0..N-1`. It returns the fitted slope, and optionally the intercept, as signed fixed-point values with `FRAC_W` fractional bits. It sits between the sample capture front-end and the host result register, and computes all products and sums internally, so the caller supplies only `y`.

---
 rtl/lsr_pkg.sv | 79 +++++++
 rtl/lsr_serial_div.sv | 83 ++++++++
 rtl/lsr_stream.sv | 267 ++++++++++++++++++++++++++
 tb/tb_lsr_stream.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsr_pkg.sv
// ---------------------------------------------------------------------------
// lsr_pkg -- shared types and elaboration-time helpers for lsr_stream.
//
// Contents:
//   lsr_state_e    FSM state encoding. ST_DIV_I exists only when
//                  LSR_INTERCEPT_EN is defined.
//   lsr_num_w      numerator width for a given sample width and point count
//   lsr_sx         sum of x over 0..N-1
//   lsr_sxx        sum of x^2 over 0..N-1
//   lsr_den        common denominator N*Sxx - Sx^2
//   lsr_saturate   clamp a signed 64-bit value to a signed out_w-bit range
//
// Configuration macro: LSR_INTERCEPT_EN (adds the intercept state).
// ---------------------------------------------------------------------------
package lsr_pkg;

`ifdef LSR_INTERCEPT_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_CALC  = 3'd2,
    ST_DIV_S = 3'd3,
    ST_DIV_I = 3'd4,
    ST_DONE  = 3'd5
  } lsr_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_CALC  = 3'd2,
    ST_DIV_S = 3'd3,
    ST_DONE  = 3'd5
  } lsr_state_e;
`endif

  // Result of a saturation: clamped value plus a flag saying it was clamped.
  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } lsr_sat_t;

  function automatic int lsr_num_w(input int data_w, input int n);
    return data_w + 3 * $clog2(n) + 2;
  endfunction

  function automatic longint lsr_sx(input int n);
    return (longint'(n) * longint'(n - 1)) / 64'sd2;
  endfunction

  function automatic longint lsr_sxx(input int n);
    return (longint'(n - 1) * longint'(n) * longint'(2 * n - 1)) / 64'sd6;
  endfunction

  function automatic longint lsr_den(input int n);
    return longint'(n) * lsr_sxx(n) - lsr_sx(n) * lsr_sx(n);
  endfunction

  // Clamp v into [-2^(out_w-1), 2^(out_w-1)-1]. The arithmetic wraps
  // correctly for out_w == 64 as well.
  function automatic lsr_sat_t lsr_saturate(input logic signed [63:0] v,
                                            input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    lsr_sat_t           r;
    hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.ovf = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lsr_serial_div.sv
// ---------------------------------------------------------------------------
// lsr_serial_div -- unsigned restoring divider, one quotient bit per cycle.
//
// Parameters:
//   W      operand and quotient width; a division takes exactly W iterations
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   load   capture num/den and start a division (ignored state is discarded)
//   num    dividend, unsigned
//   den    divisor, unsigned, must be non-zero
//   quo    quotient, valid while done is high
//   done   high from the cycle after the last iteration until the next load
//
// Timing: load edge, then W iteration edges; done rises on the W-th.
// ---------------------------------------------------------------------------
module lsr_serial_div #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic [W-1:0] quo,
  output logic         done
);

  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic [W-1:0]     den_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  logic [W:0] rem_sh;
  logic [W:0] rem_sub;
  logic       take;

  always_comb begin
    rem_sh  = {rem_q, quo_q[W-1]};
    rem_sub = rem_sh - {1'b0, den_q};
    take    = (rem_sh >= {1'b0, den_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= num;
      den_q  <= den;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      // The remainder stays below den, so it always fits back into W bits.
      if (take) begin
        rem_q <= W'(rem_sub);
        quo_q <= {quo_q[W-2:0], 1'b1};
      end else begin
        rem_q <= W'(rem_sh);
        quo_q <= {quo_q[W-2:0], 1'b0};
      end
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(W - 1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign quo  = quo_q;
  assign done = done_q;

endmodule

// File: rtl/lsr_stream.sv
// ---------------------------------------------------------------------------
// lsr_stream -- streaming least-squares line fit over N samples y[0..N-1]
// with implicit abscissa x = 0..N-1. Produces slope (and optionally the
// intercept) as signed fixed point with FRAC_W fractional bits, truncated
// toward zero and saturated to OUT_W bits.
//
// Configuration macro: LSR_INTERCEPT_EN. When undefined there is no
// intercept path; the intercept port reads 0 and never sets overflow.
//
// Parameters: DATA_W sample width, N points per fit (2..1024), FRAC_W
// fractional bits, OUT_W result width. DATA_W + 3*clog2(N) + FRAC_W must
// stay below 62 so the signed quotient fits the 64-bit saturation path.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               opens a fit; honoured only when idle
//   s_valid/s_ready     sample stream, s_data signed DATA_W
//   m_valid/m_ready     result handshake
//   slope, intercept    signed OUT_W results, stable while m_valid && !m_ready
//   overflow            a result was clamped; qualified by m_valid
//   busy                high whenever the engine is not idle
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the source holds data stable while valid && !ready. s_ready is
// high only while accumulating; m_valid holds until m_ready is seen.
//
// The FSM state register state_q is the probe point for external checkers.
// ---------------------------------------------------------------------------
module lsr_stream
  import lsr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N      = 7,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  slope,
  output logic signed [OUT_W-1:0]  intercept,
  output logic                     overflow,
  output logic                     busy
);

  localparam int NUM_W = lsr_num_w(DATA_W, N);
  localparam int DIV_W = NUM_W + FRAC_W;
  localparam int IDX_W = $clog2(N);

  localparam logic signed [NUM_W-1:0] C_N   = NUM_W'(N);
  localparam logic signed [NUM_W-1:0] C_SX  = NUM_W'(lsr_sx(N));
`ifdef LSR_INTERCEPT_EN
  localparam logic signed [NUM_W-1:0] C_SXX = NUM_W'(lsr_sxx(N));
`endif
  localparam logic [DIV_W-1:0]        C_DEN = DIV_W'(lsr_den(N));
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N - 1);

  // Control and registered outputs
  lsr_state_e             state_q;
  logic                   s_ready_q;
  logic                   m_valid_q;
  logic                   busy_q;
  logic                   ovf_q;
  logic signed [OUT_W-1:0] slope_q;
  logic signed [OUT_W-1:0] icpt_q;
  logic                   calc_ph_q;   // CALC runs two phases: products, then differences
  logic                   div_run_q;   // current division has been loaded

  // Datapath registers
  logic [IDX_W-1:0]        idx_q;
  logic signed [NUM_W-1:0] sy_q;
  logic signed [NUM_W-1:0] sxy_q;
  logic signed [NUM_W-1:0] prod_a_q;   // N * Sxy
  logic signed [NUM_W-1:0] prod_b_q;   // Sx * Sy
  logic signed [NUM_W-1:0] nxy_q;
`ifdef LSR_INTERCEPT_EN
  logic signed [NUM_W-1:0] prod_c_q;   // Sxx * Sy
  logic signed [NUM_W-1:0] prod_d_q;   // Sx * Sxy
  logic signed [NUM_W-1:0] ixy_q;
`endif

  // Combinational next values
  logic signed [NUM_W-1:0] y_ext;
  logic signed [NUM_W-1:0] idx_ext;
  logic signed [NUM_W-1:0] sy_d;
  logic signed [NUM_W-1:0] sxy_d;
  logic signed [NUM_W-1:0] cur_num;
  logic                    cur_neg;
  logic [NUM_W-1:0]        cur_mag;
  logic [DIV_W-1:0]        div_num;
  logic                    div_load;
  logic [DIV_W-1:0]        div_quo;
  logic                    div_done;
  logic signed [DIV_W:0]   quo_s;
  logic signed [DIV_W:0]   quo_signed;
  lsr_sat_t                sat_r;

  // All sums and products are kept modulo 2^NUM_W. The true numerators fit
  // in NUM_W signed bits, so the wrapped intermediate products still yield
  // the exact differences.
  always_comb begin
    y_ext   = NUM_W'(s_data);
    idx_ext = NUM_W'({1'b0, idx_q});
    sy_d    = sy_q + y_ext;
    sxy_d   = sxy_q + idx_ext * y_ext;

`ifdef LSR_INTERCEPT_EN
    cur_num  = (state_q == ST_DIV_I) ? ixy_q : nxy_q;
    div_load = ((state_q == ST_DIV_S) || (state_q == ST_DIV_I)) && !div_run_q;
`else
    cur_num  = nxy_q;
    div_load = (state_q == ST_DIV_S) && !div_run_q;
`endif
    // Divide magnitudes and reapply the sign, so the quotient truncates
    // toward zero. The most negative numerator still has a valid unsigned
    // magnitude in NUM_W bits.
    cur_neg    = cur_num[NUM_W-1];
    cur_mag    = cur_neg ? -cur_num : cur_num;
    div_num    = {cur_mag, {FRAC_W{1'b0}}};
    quo_s      = {1'b0, div_quo};
    quo_signed = cur_neg ? -quo_s : quo_s;
    sat_r      = lsr_saturate(64'(quo_signed), OUT_W);
  end

  lsr_serial_div #(
    .W (DIV_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (div_load),
    .num   (div_num),
    .den   (C_DEN),
    .quo   (div_quo),
    .done  (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      slope_q   <= '0;
      icpt_q    <= '0;
      calc_ph_q <= 1'b0;
      div_run_q <= 1'b0;
      idx_q     <= '0;
      sy_q      <= '0;
      sxy_q     <= '0;
      prod_a_q  <= '0;
      prod_b_q  <= '0;
      nxy_q     <= '0;
`ifdef LSR_INTERCEPT_EN
      prod_c_q  <= '0;
      prod_d_q  <= '0;
      ixy_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_ACCUM;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            idx_q     <= '0;
            sy_q      <= '0;
            sxy_q     <= '0;
          end
        end

        ST_ACCUM: begin
          if (s_valid && s_ready_q) begin
            sy_q  <= sy_d;
            sxy_q <= sxy_d;
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_q   <= ST_CALC;
              s_ready_q <= 1'b0;
              calc_ph_q <= 1'b0;
            end
          end
        end

        ST_CALC: begin
          if (!calc_ph_q) begin
            prod_a_q  <= C_N * sxy_q;
            prod_b_q  <= C_SX * sy_q;
`ifdef LSR_INTERCEPT_EN
            prod_c_q  <= C_SXX * sy_q;
            prod_d_q  <= C_SX * sxy_q;
`endif
            calc_ph_q <= 1'b1;
          end else begin
            nxy_q     <= prod_a_q - prod_b_q;
`ifdef LSR_INTERCEPT_EN
            ixy_q     <= prod_c_q - prod_d_q;
`endif
            ovf_q     <= 1'b0;
            div_run_q <= 1'b0;
            state_q   <= ST_DIV_S;
          end
        end

        ST_DIV_S: begin
          // First cycle issues the load; the stale done of a previous
          // division is ignored until the load has taken effect.
          if (!div_run_q) begin
            div_run_q <= 1'b1;
          end else if (div_done) begin
            slope_q   <= OUT_W'(sat_r.val);
            ovf_q     <= sat_r.ovf;
            div_run_q <= 1'b0;
`ifdef LSR_INTERCEPT_EN
            state_q   <= ST_DIV_I;
`else
            state_q   <= ST_DONE;
            m_valid_q <= 1'b1;
`endif
          end
        end

`ifdef LSR_INTERCEPT_EN
        ST_DIV_I: begin
          if (!div_run_q) begin
            div_run_q <= 1'b1;
          end else if (div_done) begin
            icpt_q    <= OUT_W'(sat_r.val);
            ovf_q     <= ovf_q | sat_r.ovf;
            div_run_q <= 1'b0;
            state_q   <= ST_DONE;
            m_valid_q <= 1'b1;
          end
        end
`endif

        ST_DONE: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign slope     = slope_q;
  assign intercept = icpt_q;

endmodule

// File: tb/tb_lsr_stream.sv
// ---------------------------------------------------------------------------
// tb_lsr_stream -- self-checking bench for lsr_stream. Two instances share
// the stimulus: dut_a with OUT_W=32 and dut_b with OUT_W=16 (saturation).
// The reference model fits the line from the sample list directly with
// 64-bit arithmetic and queues the expected results per fit.
// ---------------------------------------------------------------------------
module tb_lsr_stream;

  localparam int N       = 7;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int NUM_W   = DATA_W + 3 * $clog2(N) + 2;
  localparam int DIV_CYC = NUM_W + FRAC_W;
`ifdef LSR_INTERCEPT_EN
  localparam bit ICPT    = 1'b1;
  localparam int EXP_LAT = 2 * DIV_CYC + 6;
`else
  localparam bit ICPT    = 1'b0;
  localparam int EXP_LAT = DIV_CYC + 4;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                     start = 1'b0;
  logic                     s_valid = 1'b0;
  logic signed [DATA_W-1:0] s_data = '0;
  logic                     m_ready = 1'b0;

  logic                     s_ready_a, m_valid_a, ovf_a, busy_a;
  logic signed [31:0]       slope_a, icpt_a;
  logic                     s_ready_b, m_valid_b, ovf_b, busy_b;
  logic signed [15:0]       slope_b, icpt_b;

  lsr_stream #(.DATA_W(DATA_W), .N(N), .FRAC_W(FRAC_W), .OUT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .m_valid(m_valid_a), .m_ready(m_ready),
    .slope(slope_a), .intercept(icpt_a), .overflow(ovf_a), .busy(busy_a)
  );

  lsr_stream #(.DATA_W(DATA_W), .N(N), .FRAC_W(FRAC_W), .OUT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .m_valid(m_valid_b), .m_ready(m_ready),
    .slope(slope_b), .intercept(icpt_b), .overflow(ovf_b), .busy(busy_b)
  );

  // ---------------- scoreboard ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic signed [DATA_W-1:0] ys [N];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w, output bit o);
    longint hi;
    longint lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    o  = 1'b0;
    if (v > hi) begin o = 1'b1; return hi; end
    if (v < lo) begin o = 1'b1; return lo; end
    return v;
  endfunction

  // Least-squares fit straight from the sample list; '/' on longint
  // truncates toward zero, which is the required rounding.
  task automatic model_push();
    longint sy, sxy, sx, sxx, d, nxy, ixy, qs, qi, es, ei;
    bit     os, oi;
    int     w;
    sy = 0; sxy = 0; sx = 0; sxx = 0;
    for (int i = 0; i < N; i++) begin
      sy  += longint'(ys[i]);
      sxy += longint'(i) * longint'(ys[i]);
      sx  += i;
      sxx += i * i;
    end
    d   = N * sxx - sx * sx;
    nxy = N * sxy - sx * sy;
    ixy = sxx * sy - sx * sxy;
    qs  = (nxy * 256) / d;
    qi  = (ixy * 256) / d;
    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? 32 : 16;
      es = sat(qs, w, os);
      ei = sat(qi, w, oi);
      if (!ICPT) begin ei = 0; oi = 1'b0; end
      exp_q.push_back(es);
      exp_q.push_back(ei);
      exp_q.push_back({63'd0, os | oi});
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic check_reset(input string tag);
    chk({tag, "_s_ready_a"}, s_ready_a, 0);
    chk({tag, "_m_valid_a"}, m_valid_a, 0);
    chk({tag, "_busy_a"},    busy_a,    0);
    chk({tag, "_ovf_a"},     ovf_a,     0);
    chk({tag, "_slope_a"},   slope_a,   0);
    chk({tag, "_icpt_a"},    icpt_a,    0);
    chk({tag, "_s_ready_b"}, s_ready_b, 0);
    chk({tag, "_m_valid_b"}, m_valid_b, 0);
    chk({tag, "_busy_b"},    busy_b,    0);
    chk({tag, "_slope_b"},   slope_b,   0);
  endtask

  task automatic run_fit(input string tag, input int gap_max, input int hold,
                         input bit junk_start, input bit poke);
    int          lat;
    bit          ok;
    bit          stable;
    logic [63:0] e [6];
    logic signed [31:0] sa, ia;
    logic signed [15:0] sb, ib;
    logic        oa, ob;
    model_push();
    start = 1'b1;
    if (junk_start) begin s_valid = 1'b1; s_data = 16'sh1234; end
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0;
    chk({tag, "_s_ready_up"}, s_ready_a, 1);
    chk({tag, "_busy_up"}, busy_a, 1);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      s_valid = 1'b1;
      s_data  = ys[i];
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        ok = s_ready_a;
        @(posedge clk); #1;
      end
      s_valid = 1'b0;
      chk({tag, "_sample_taken"}, ok, 1);
    end
    chk({tag, "_s_ready_down"}, s_ready_a, 0);
    chk({tag, "_busy_calc"}, busy_a, 1);
    lat = 0;
    while (!m_valid_a && lat < 300) begin
      if (poke && lat == 10) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk({tag, "_latency"}, lat, EXP_LAT);
    chk({tag, "_m_valid_b"}, m_valid_b, 1);
    sa = slope_a; ia = icpt_a; oa = ovf_a;
    sb = slope_b; ib = icpt_b; ob = ovf_b;
    stable = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (m_valid_a !== 1'b1 || m_valid_b !== 1'b1 || slope_a !== sa ||
          icpt_a !== ia || ovf_a !== oa || slope_b !== sb ||
          icpt_b !== ib || ovf_b !== ob)
        stable = 1'b0;
    end
    chk({tag, "_hold_stable"}, stable, 1);
    for (int k = 0; k < 6; k++) e[k] = exp_q.pop_front();
    chk({tag, "_slope_a"}, slope_a, e[0]);
    chk({tag, "_icpt_a"},  icpt_a,  e[1]);
    chk({tag, "_ovf_a"},   ovf_a,   e[2]);
    chk({tag, "_slope_b"}, slope_b, e[3]);
    chk({tag, "_icpt_b"},  icpt_b,  e[4]);
    chk({tag, "_ovf_b"},   ovf_b,   e[5]);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk({tag, "_m_valid_clear"}, m_valid_a, 0);
    chk({tag, "_busy_clear"}, busy_a, 0);
    chk({tag, "_slope_persist"}, slope_a, e[0]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp 5 + 3x
    ys = '{16'sd5, 16'sd8, 16'sd11, 16'sd14, 16'sd17, 16'sd20, 16'sd23};
    run_fit("ramp", 0, 0, 1'b0, 1'b0);
    chk("ramp_const_slope", slope_a, 768);
    chk("ramp_const_icpt", icpt_a, ICPT ? 1280 : 0);
    chk("ramp_const_ovf", ovf_a, 0);

    // Constant -100
    for (int i = 0; i < N; i++) ys[i] = -16'sd100;
    run_fit("const", 0, 0, 1'b0, 1'b0);
    chk("const_slope", slope_a, 0);
    chk("const_icpt", icpt_a, ICPT ? -25600 : 0);

    // Single step at the end: truncation toward zero on both signs
    ys = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd1};
    run_fit("trunc", 0, 0, 1'b0, 1'b0);
    chk("trunc_slope", slope_a, 27);
    chk("trunc_icpt", icpt_a, ICPT ? -45 : 0);

    // 4096*x: fits in 32 bits, saturates in 16 bits
    for (int i = 0; i < N; i++) ys[i] = 16'(4096 * i);
    run_fit("steep", 0, 0, 1'b0, 1'b0);
    chk("steep_slope_a", slope_a, 1048576);
    chk("steep_slope_b", slope_b, 32767);
    chk("steep_ovf_b", ovf_b, 1);

    // Ramp again with stream gaps, start+s_valid collision and start pokes
    ys = '{16'sd5, 16'sd8, 16'sd11, 16'sd14, 16'sd17, 16'sd20, 16'sd23};
    run_fit("ramp_gaps", 3, 0, 1'b1, 1'b1);
    chk("ramp_gaps_slope", slope_a, 768);

    // Result backpressure for 10 cycles
    for (int i = 0; i < N; i++) ys[i] = 16'($urandom_range(0, 65535));
    run_fit("hold10", 0, 10, 1'b0, 1'b0);

    // Random fits
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) ys[i] = 16'($urandom_range(0, 65535));
      run_fit($sformatf("rnd%0d", r), $urandom_range(0, 2),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    // Reset after 3 samples, then a clean fit
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 16'sd7000;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk); #1;
    rst_n   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'sd7000;
    repeat (2) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("midrst_no_restart_ready", s_ready_a, 0);
    chk("midrst_no_restart_busy", busy_a, 0);
    ys = '{16'sd5, 16'sd8, 16'sd11, 16'sd14, 16'sd17, 16'sd20, 16'sd23};
    run_fit("after_rst", 0, 0, 1'b0, 1'b0);
    chk("after_rst_slope", slope_a, 768);
    chk("after_rst_icpt", icpt_a, ICPT ? 1280 : 0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
